writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Writer side of the register-file write port (regWrite / addrDestination / writeData).
- Accepts results from the execute and load paths through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drains at most one entry per cycle into the register file.
- Exposes a pending-write scoreboard so decode can detect RAW hazards on rs/rt.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 5, register address width.
- DATA_W, 32, result data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept this cycle.
- in_dest  input  ADDR_W  destination register.
- in_data  input  DATA_W  result value.
- wb_stall  input  1  inhibits draining this cycle.
- regWrite  output  1  register-file write enable.
- addrDestination  output  ADDR_W  register-file write address.
- writeData  output  DATA_W  register-file write data.
- rs_addr  input  ADDR_W  decode source register A.
- rt_addr  input  ADDR_W  decode source register B.
- rs_busy  output  1  a queued write targets rs_addr.
- rt_busy  output  1  a queued write targets rt_addr.
- rs_fwd_data  output  DATA_W  forwarded value for rs (see Optional Feature).
- rt_fwd_data  output  DATA_W  forwarded value for rt (see Optional Feature).
- count  output  clog2(DEPTH)+1  current number of entries.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, count and all entry valid bits go to 0.
  - regWrite, addrDestination, writeData, busy and fwd outputs are all 0.
  - in_ready is 1 after release.
  - Reset mid-drain loses all queued entries; this is the required behaviour.
- Push:
  - in_ready = (count != DEPTH).
  - Accept on a rising edge when in_valid && in_ready && !flush.
  - in_dest == 0: the handshake completes, but nothing is enqueued and count is unchanged.
- Drain:
  - regWrite = (count != 0) && !wb_stall && !flush.
  - addrDestination / writeData present the head entry when count != 0, and 0 when empty.
  - The entry pops on the same edge the register file captures the write (zero extra latency).
  - Writes leave in strict FIFO order.
- Latency:
  - A result accepted at edge N appears on regWrite in the cycle after edge N if the queue was empty and wb_stall is low.
  - It is written at edge N+1.
- Push and pop in the same cycle:
  - Count is unchanged.
  - When full, in_ready stays 0 even if a pop occurs that cycle (no pass-through).
- Pointers:
  - Read and write pointers wrap modulo DEPTH.
  - Count saturates at neither end; an overflow or underflow condition is impossible by construction and is to be asserted in simulation.
- Flush:
  - Overrides push and pop.
  - On the next edge count goes to 0 and all valid bits clear.
  - regWrite is forced low during the flush cycle.
- Scoreboard:
  - rs_busy = OR over valid entries of (dest == rs_addr) && (rs_addr != 0); rt_busy is analogous.
  - Purely combinational from current state; the head entry being written this cycle still reports busy.
  - An entry being pushed this cycle does not report busy until the next cycle.
- Duplicate destinations in the queue are legal; the youngest entry wins at the register file by ordering.

Optional Feature:
- Macro: WBQ_FORWARD_EN.
- Defined:
  - rs_fwd_data / rt_fwd_data return the data of the youngest valid entry matching rs_addr / rt_addr.
  - The value is 0 when the corresponding busy bit is 0.
  - This is a priority search from tail to head.
- Not defined:
  - rs_fwd_data and rt_fwd_data are tied to 0.
  - No comparison or mux logic is synthesised.
  - Busy outputs are unchanged.

Test Plan:
1. Reset then idle: hold rst=0 for 2 cycles and release -> all outputs 0, in_ready=1, count=0.
2. Single write: push dest=5, data=0xDEADBEEF with wb_stall=0 -> next cycle regWrite=1, addrDestination=5, writeData=0xDEADBEEF; count returns to 0 after that edge.
3. Fill and back-pressure: wb_stall=1, push dests 1..4 -> count=4, in_ready=0; 5th push is not accepted; release wb_stall -> writes appear in order 1,2,3,4 on consecutive cycles.
4. Register zero: push dest=0, data=0x1234 -> handshake completes, count stays 0, regWrite never asserts, rs_busy=0 when rs_addr=0.
5. Scoreboard and forwarding: wb_stall=1, push (7,0xA) then (7,0xB); set rs_addr=7, rt_addr=8 -> rs_busy=1, rt_busy=0; with WBQ_FORWARD_EN, rs_fwd_data=0xB; without it, rs_fwd_data=0.
6. Flush and async reset: with 3 entries queued, pulse flush -> regWrite=0 that cycle and count=0 next cycle; then queue 2 entries and drop rst mid-cycle -> outputs go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file write-back FIFO with a pending-write scoreboard for RAW hazard detection.
// Define WBQ_FORWARD_EN to return the youngest matching queued value on rs/rt_fwd_data.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_dest,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     wb_stall,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        addrDestination,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        rs_addr,
    input  logic [ADDR_W-1:0]        rt_addr,
    output logic                     rs_busy,
    output logic                     rt_busy,
    output logic [DATA_W-1:0]        rs_fwd_data,
    output logic [DATA_W-1:0]        rt_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data;
    logic [DEPTH-1:0]             ent_vld;
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic                         empty, accept, enq, pop;
    logic [DEPTH-1:0]             rs_hit, rt_hit;

    assign empty    = (count == '0);
    assign in_ready = (count != FULL);
    assign accept   = in_valid && in_ready && !flush;
    // Writes to r0 complete the handshake but are never queued.
    assign enq      = accept && (in_dest != '0);
    assign regWrite = !empty && !wb_stall && !flush;
    assign pop      = regWrite;

    assign addrDestination = empty ? '0 : ent_dest[rd_ptr];
    assign writeData       = empty ? '0 : ent_data[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            // enq and pop never target the same slot: that needs empty or full,
            // where pop or enq respectively is blocked.
            if (enq) begin
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            unique case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            ent_dest[wr_ptr] <= in_dest;
            ent_data[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit[i] = ent_vld[i] && (ent_dest[i] == rs_addr);
            rt_hit[i] = ent_vld[i] && (ent_dest[i] == rt_addr);
        end
    end

    assign rs_busy = (|rs_hit) && (rs_addr != '0);
    assign rt_busy = (|rt_hit) && (rt_addr != '0);

`ifdef WBQ_FORWARD_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    function automatic logic [DATA_W-1:0] youngest(input logic [DEPTH-1:0] hit);
        logic [PW-1:0] idx;
        youngest = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (hit[idx]) youngest = ent_data[idx];
        end
    endfunction

    assign rs_fwd_data = rs_busy ? youngest(rs_hit) : '0;
    assign rt_fwd_data = rt_busy ? youngest(rt_hit) : '0;
`else
    assign rs_fwd_data = '0;
    assign rt_fwd_data = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(enq && !pop && (count == FULL)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && !enq && (count == '0)));

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vector table, randomized run against a queue
// model, and hand sequences for flush and asynchronous reset.
module tb_writeback_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, wb_stall, regWrite;
    logic [4:0]  in_dest, addrDestination, rs_addr, rt_addr;
    logic [31:0] in_data, writeData, rs_fwd_data, rt_fwd_data;
    logic        rs_busy, rt_busy;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_data(in_data), .wb_stall(wb_stall), .regWrite(regWrite),
        .addrDestination(addrDestination), .writeData(writeData),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data), .count(count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic v; logic [4:0] dest; logic [31:0] data; logic stall;
        logic [4:0] rs, rt;
        logic e_rdy, e_we; logic [4:0] e_addr; logic [31:0] e_wd;
        logic e_rsb, e_rtb; logic [31:0] e_fwd; logic [2:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [4:0] dest, input logic [31:0] data,
                                input logic stall, input logic [4:0] rs, input logic [4:0] rt,
                                input logic rdy, input logic we, input logic [4:0] addr,
                                input logic [31:0] wd, input logic rsb, input logic rtb,
                                input logic [31:0] fwd, input logic [2:0] cnt);
        vec_t r;
        r.v = v; r.dest = dest; r.data = data; r.stall = stall; r.rs = rs; r.rt = rt;
        r.e_rdy = rdy; r.e_we = we; r.e_addr = addr; r.e_wd = wd;
        r.e_rsb = rsb; r.e_rtb = rtb; r.e_fwd = fwd; r.e_cnt = cnt;
        return r;
    endfunction

    typedef struct { logic [4:0] dest; logic [31:0] data; } ent_t;
    ent_t mq[$];

    task automatic drive(input logic v, input logic [4:0] d, input logic [31:0] x,
                         input logic st, input logic fl, input logic [4:0] rs, input logic [4:0] rt);
        in_valid = v; in_dest = d; in_data = x; wb_stall = st; flush = fl;
        rs_addr = rs; rt_addr = rt;
    endtask

    // Model step: expected outputs from the queue contents, then apply the edge.
    task automatic model_cycle();
        int sz;
        logic e_rdy, e_we, e_rsb, e_rtb;
        logic [4:0] e_addr;
        logic [31:0] e_wd, e_rsf, e_rtf;
        sz = mq.size();
        e_rdy = (sz != DEPTH);
        e_we = (sz != 0) && !wb_stall && !flush;
        e_addr = (sz != 0) ? mq[0].dest : 5'd0;
        e_wd = (sz != 0) ? mq[0].data : 32'd0;
        e_rsb = 1'b0; e_rtb = 1'b0; e_rsf = 32'd0; e_rtf = 32'd0;
        for (int i = 0; i < sz; i++) begin
            if (rs_addr != 0 && mq[i].dest == rs_addr) begin e_rsb = 1'b1; e_rsf = mq[i].data; end
            if (rt_addr != 0 && mq[i].dest == rt_addr) begin e_rtb = 1'b1; e_rtf = mq[i].data; end
        end
        if (!FWD) begin e_rsf = 32'd0; e_rtf = 32'd0; end
        chk("rnd_count", 32'(count), 32'(sz));
        chk("rnd_in_ready", 32'(in_ready), 32'(e_rdy));
        chk("rnd_regWrite", 32'(regWrite), 32'(e_we));
        chk("rnd_addr", 32'(addrDestination), 32'(e_addr));
        chk("rnd_data", writeData, e_wd);
        chk("rnd_rs_busy", 32'(rs_busy), 32'(e_rsb));
        chk("rnd_rt_busy", 32'(rt_busy), 32'(e_rtb));
        chk("rnd_rs_fwd", rs_fwd_data, e_rsf);
        chk("rnd_rt_fwd", rt_fwd_data, e_rtf);
        if (flush) mq.delete();
        else begin
            if (e_we) void'(mq.pop_front());
            if (in_valid && e_rdy && in_dest != 0) mq.push_back('{in_dest, in_data});
        end
    endtask

    initial begin
        logic [31:0] fb;
        fb = FWD ? 32'hB : 32'h0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_regWrite", 32'(regWrite), 0);
        chk("rst_addr", 32'(addrDestination), 0);
        chk("rst_data", writeData, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_count", 32'(count), 0);
        chk("idle_busy", 32'({rs_busy, rt_busy}), 0);
        @(posedge clk); #1;

        //            v  dst data          st rs rt  rdy we addr wd           rsb rtb fwd cnt
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0,  1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 1, 32'h11,       1, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 2, 32'h22,       1, 0, 0, 1, 0, 1, 32'h11,       0, 0, 0,  1));
        tbl.push_back(mk(1, 3, 32'h33,       1, 0, 0, 1, 0, 1, 32'h11,       0, 0, 0,  2));
        tbl.push_back(mk(1, 4, 32'h44,       1, 0, 0, 1, 0, 1, 32'h11,       0, 0, 0,  3));
        tbl.push_back(mk(1, 5, 32'h55,       1, 0, 0, 0, 0, 1, 32'h11,       0, 0, 0,  4));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 0, 1, 1, 32'h11,       0, 0, 0,  4));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 1, 2, 32'h22,       0, 0, 0,  3));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 1, 3, 32'h33,       0, 0, 0,  2));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 1, 4, 32'h44,       0, 0, 0,  1));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 7, 32'hA,        1, 0, 0, 1, 0, 0, 0,            0, 0, 0,  0));
        tbl.push_back(mk(1, 7, 32'hB,        1, 0, 0, 1, 0, 7, 32'hA,        0, 0, 0,  1));
        tbl.push_back(mk(0, 0, 0,            1, 7, 8, 1, 0, 7, 32'hA,        1, 0, fb, 2));
        tbl.push_back(mk(0, 0, 0,            0, 7, 8, 1, 1, 7, 32'hA,        1, 0, fb, 2));
        tbl.push_back(mk(0, 0, 0,            0, 7, 8, 1, 1, 7, 32'hB,        1, 0, fb, 1));
        tbl.push_back(mk(0, 0, 0,            0, 7, 8, 1, 0, 0, 0,            0, 0, 0,  0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].dest, tbl[i].data, tbl[i].stall, 0, tbl[i].rs, tbl[i].rt);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_regWrite", i), 32'(regWrite), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d_addr", i), 32'(addrDestination), 32'(tbl[i].e_addr));
            chk($sformatf("vec%0d_data", i), writeData, tbl[i].e_wd);
            chk($sformatf("vec%0d_rs_busy", i), 32'(rs_busy), 32'(tbl[i].e_rsb));
            chk($sformatf("vec%0d_rt_busy", i), 32'(rt_busy), 32'(tbl[i].e_rtb));
            chk($sformatf("vec%0d_rs_fwd", i), rs_fwd_data, tbl[i].e_fwd);
            chk($sformatf("vec%0d_rt_fwd", i), rt_fwd_data, 0);
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            @(posedge clk); #1;
        end

        // Randomized run against the queue model (queue is empty here)
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clk);
            model_cycle();
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        mq.delete();

        // Flush with three entries queued
        drive(1, 9, 32'h90, 1, 0, 0, 0);  @(posedge clk); #1;
        drive(1, 10, 32'hA0, 1, 0, 0, 0); @(posedge clk); #1;
        drive(1, 11, 32'hB0, 1, 0, 0, 0); @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 9, 0);
        @(negedge clk);
        chk("flush_regWrite", 32'(regWrite), 0);
        chk("flush_count_before", 32'(count), 3);
        chk("flush_rs_busy_before", 32'(rs_busy), 1);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 0, 9, 0);
        @(negedge clk);
        chk("flush_count_after", 32'(count), 0);
        chk("flush_rs_busy_after", 32'(rs_busy), 0);
        chk("flush_regWrite_after", 32'(regWrite), 0);
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle with two entries queued
        drive(1, 12, 32'hC0, 1, 0, 0, 0); @(posedge clk); #1;
        drive(1, 13, 32'hD0, 1, 0, 0, 0); @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 12, 0);
        #1;
        chk("pre_rst_regWrite", 32'(regWrite), 1);
        chk("pre_rst_count", 32'(count), 2);
        chk("pre_rst_fwd", rs_fwd_data, FWD ? 32'hC0 : 32'h0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_regWrite", 32'(regWrite), 0);
        chk("async_rst_count", 32'(count), 0);
        chk("async_rst_addr", 32'(addrDestination), 0);
        chk("async_rst_data", writeData, 0);
        chk("async_rst_rs_busy", 32'(rs_busy), 0);
        chk("async_rst_rs_fwd", rs_fwd_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_regWrite", 32'(regWrite), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
